// File: rtl/video_raw_decoder_pkg.sv
// Shared video timing package: pulse classes, sync states and 12 MHz
// timing defaults used by the raw decoder and by video generator blocks.
package video_raw_decoder_pkg;

    typedef enum logic [1:0] {
        CLS_INVALID = 2'd0,
        CLS_SHORT   = 2'd1,
        CLS_HSYNC   = 2'd2,
        CLS_BROAD   = 2'd3
    } pulse_class_t;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } sync_state_t;

    localparam int SHORT_MIN_DEF = 20;
    localparam int SHORT_MAX_DEF = 40;
    localparam int HSYNC_MIN_DEF = 45;
    localparam int HSYNC_MAX_DEF = 80;
    localparam int BROAD_MIN_DEF = 250;
    localparam int BROAD_MAX_DEF = 360;
    localparam int X_START_DEF   = 187;
    localparam int X_WIDTH_DEF   = 499;
    localparam int Y_FIRST_DEF   = 51;
    localparam int Y_LAST_DEF    = 280;
    localparam int NUM_BROAD_DEF = 5;

    localparam logic [9:0] CNT_MAX      = 10'd1023;
    localparam logic [8:0] LINE_NO_MAX  = 9'd308;
    localparam logic [8:0] LINE_NO_LOCK = 9'd4;

    function automatic pulse_class_t classify(
        input logic [10:0] width,
        input int smin, input int smax,
        input int hmin, input int hmax,
        input int bmin, input int bmax
    );
        int w;
        w = int'(width);
        if (w >= smin && w <= smax) return CLS_SHORT;
        if (w >= hmin && w <= hmax) return CLS_HSYNC;
        if (w >= bmin && w <= bmax) return CLS_BROAD;
        return CLS_INVALID;
    endfunction

endpackage

// File: rtl/video_raw_decoder_if.sv
// Recovered pixel stream: pixel value plus its coordinates and valid flag.
interface video_raw_decoder_if;

    logic       o_pixel;
    logic       o_enable;
    logic [8:0] o_pixel_x;
    logic [7:0] o_pixel_y;

    modport master (
        output o_pixel, o_enable, o_pixel_x, o_pixel_y
    );

    modport slave (
        input o_pixel, o_enable, o_pixel_x, o_pixel_y
    );

endinterface

// File: rtl/video_raw_decoder_classifier.sv
// Input registers, sync edge detection and low-pulse width classification.
module video_pulse_classifier
    import video_raw_decoder_pkg::*;
#(
    parameter int SHORT_MIN = SHORT_MIN_DEF,
    parameter int SHORT_MAX = SHORT_MAX_DEF,
    parameter int HSYNC_MIN = HSYNC_MIN_DEF,
    parameter int HSYNC_MAX = HSYNC_MAX_DEF,
    parameter int BROAD_MIN = BROAD_MIN_DEF,
    parameter int BROAD_MAX = BROAD_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_sync,
    input  logic         i_white,
    output logic         sync_q,
    output logic         white_q,
    output logic         fall,
    output logic         pulse_valid,
    output pulse_class_t pulse_class,
    output logic         low_sat
);

    logic       sync_d;
    logic [9:0] low_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 1'b1;
            sync_d  <= 1'b1;
            white_q <= 1'b0;
            low_cnt <= '0;
        end else begin
            sync_q  <= i_sync;
            sync_d  <= sync_q;
            white_q <= i_white;
            if (fall)
                low_cnt <= '0;
            else if (!sync_q && low_cnt != CNT_MAX)
                low_cnt <= low_cnt + 10'd1;
        end
    end

    assign fall        = sync_d & ~sync_q;
    assign pulse_valid = ~sync_d & sync_q;

    // low_cnt lags the pulse by one clock, so the true width is low_cnt+1
    assign pulse_class = classify(11'(low_cnt) + 11'd1,
                                  SHORT_MIN, SHORT_MAX,
                                  HSYNC_MIN, HSYNC_MAX,
                                  BROAD_MIN, BROAD_MAX);

    assign low_sat = ~sync_q & ~fall & (low_cnt == CNT_MAX - 10'd1);

endmodule

// File: rtl/video_raw_decoder.sv
// Composite sync decoder: line/frame tracking and pixel coordinate output.
module video_raw_decoder
    import video_raw_decoder_pkg::*;
#(
    parameter int SHORT_MIN = SHORT_MIN_DEF,
    parameter int SHORT_MAX = SHORT_MAX_DEF,
    parameter int HSYNC_MIN = HSYNC_MIN_DEF,
    parameter int HSYNC_MAX = HSYNC_MAX_DEF,
    parameter int BROAD_MIN = BROAD_MIN_DEF,
    parameter int BROAD_MAX = BROAD_MAX_DEF,
    parameter int X_START   = X_START_DEF,
    parameter int X_WIDTH   = X_WIDTH_DEF,
    parameter int Y_FIRST   = Y_FIRST_DEF,
    parameter int Y_LAST    = Y_LAST_DEF,
    parameter int NUM_BROAD = NUM_BROAD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sync,
    input  logic                i_white,
    video_raw_decoder_if.master vid,
    output logic                o_locked,
    output logic                o_frame_start,
    output logic                o_error
);

    localparam logic [2:0] BROAD_LAST = 3'(NUM_BROAD - 1);
    localparam logic [9:0] X_LO = 10'(X_START);
    localparam logic [9:0] X_HI = 10'(X_START + X_WIDTH - 1);
    localparam logic [8:0] Y_LO = 9'(Y_FIRST);
    localparam logic [8:0] Y_HI = 9'(Y_LAST);

    logic         sync_q, white_q, fall, pulse_valid, low_sat;
    pulse_class_t pulse_class;
    sync_state_t  state_q, state_d;
    logic [9:0]   line_cnt;
    logic [8:0]   line_no, line_no_d;
    logic [2:0]   broad_cnt, broad_cnt_d;
    logic         frame_hit, lose, line_sat;
    logic         fs_d, err_d, en_d;

    video_pulse_classifier #(
        .SHORT_MIN(SHORT_MIN), .SHORT_MAX(SHORT_MAX),
        .HSYNC_MIN(HSYNC_MIN), .HSYNC_MAX(HSYNC_MAX),
        .BROAD_MIN(BROAD_MIN), .BROAD_MAX(BROAD_MAX)
    ) u_cls (
        .clk        (clk),
        .rst        (rst),
        .i_sync     (i_sync),
        .i_white    (i_white),
        .sync_q     (sync_q),
        .white_q    (white_q),
        .fall       (fall),
        .pulse_valid(pulse_valid),
        .pulse_class(pulse_class),
        .low_sat    (low_sat)
    );

    // A falling edge clears line_cnt, so it never counts as saturation
    assign line_sat  = ~fall & (line_cnt == CNT_MAX - 10'd1);
    assign frame_hit = pulse_valid && pulse_class == CLS_BROAD
                       && broad_cnt == BROAD_LAST;

    always_comb begin
        state_d     = state_q;
        line_no_d   = line_no;
        broad_cnt_d = broad_cnt;
        fs_d        = 1'b0;
        err_d       = 1'b0;
        lose        = 1'b0;
        if (frame_hit) begin
            broad_cnt_d = '0;
            line_no_d   = LINE_NO_LOCK;
            state_d     = ST_LOCKED;
            fs_d        = 1'b1;
        end else begin
            if (pulse_valid)
                broad_cnt_d = (pulse_class == CLS_BROAD) ?
                              broad_cnt + 3'd1 : 3'd0;
            if (state_q == ST_LOCKED) begin
                if (pulse_valid) begin
                    unique case (pulse_class)
                        CLS_INVALID: lose = 1'b1;
                        CLS_HSYNC: begin
                            if (line_no >= LINE_NO_MAX)
                                lose = 1'b1;
                            else
                                line_no_d = line_no + 9'd1;
                        end
                        default: ;
                    endcase
                end
                if (line_sat || low_sat)
                    lose = 1'b1;
                if (lose) begin
                    state_d = ST_SEARCH;
                    err_d   = 1'b1;
                end
            end
        end
        if (white_q && !sync_q)
            err_d = 1'b1;
    end

    assign en_d = state_q == ST_LOCKED
                  && line_no >= Y_LO && line_no <= Y_HI
                  && line_cnt >= X_LO && line_cnt <= X_HI;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SEARCH;
            line_cnt      <= '0;
            line_no       <= '0;
            broad_cnt     <= '0;
            o_locked      <= 1'b0;
            o_frame_start <= 1'b0;
            o_error       <= 1'b0;
            vid.o_enable  <= 1'b0;
            vid.o_pixel   <= 1'b0;
            vid.o_pixel_x <= '0;
            vid.o_pixel_y <= '0;
        end else begin
            state_q   <= state_d;
            line_no   <= line_no_d;
            broad_cnt <= broad_cnt_d;
            if (fall)
                line_cnt <= '0;
            else if (line_cnt != CNT_MAX)
                line_cnt <= line_cnt + 10'd1;
            o_locked      <= (state_d == ST_LOCKED);
            o_frame_start <= fs_d;
            o_error       <= err_d;
            vid.o_enable  <= en_d;
            vid.o_pixel   <= en_d & white_q;
            vid.o_pixel_x <= en_d ? 9'(line_cnt - X_LO) : 9'd0;
            vid.o_pixel_y <= en_d ? 8'(line_no - Y_LO) : 8'd0;
        end
    end

endmodule

// File: tb/tb_video_raw_decoder.sv
// Directed bench for video_raw_decoder: lock, active line, errors, reset.
module tb_video_raw_decoder;

    logic clk = 1'b0;
    logic rst, i_sync, i_white;
    logic o_locked, o_frame_start, o_error;

    video_raw_decoder_if vid();

    video_raw_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .i_sync       (i_sync),
        .i_white      (i_white),
        .vid          (vid),
        .o_locked     (o_locked),
        .o_frame_start(o_frame_start),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_fs = 0;
    int n_err = 0;
    int n_en = 0;

    // one clock: drive, step past the edge, tally pulses
    task automatic cyc(input logic s, input logic w);
        i_sync = s;
        i_white = w;
        @(posedge clk);
        #1;
        if (o_frame_start) n_fs++;
        if (o_error) n_err++;
        if (vid.o_enable) n_en++;
    endtask

    task automatic pulse(input int low, input int period, input logic w);
        for (int k = 0; k < period; k++)
            cyc(k >= low, (k >= low) ? w : 1'b0);
    endtask

    task automatic do_lock();
        pulse(30, 384, 1'b0);
        repeat (5) pulse(327, 384, 1'b0);
    endtask

    task automatic test_reset();
        int e0;
        rst = 1'b1;
        repeat (3) cyc(1'b0, 1'b1);
        checks++;
        if (o_locked !== 1'b0) begin
            failures++;
            $display("FAIL rst_locked got=%b exp=0", o_locked);
        end
        checks++;
        if ({o_frame_start, o_error} !== 2'b00) begin
            failures++;
            $display("FAIL rst_pulses got=%b exp=00", {o_frame_start, o_error});
        end
        checks++;
        if ({vid.o_enable, vid.o_pixel, vid.o_pixel_x, vid.o_pixel_y} !== 19'd0) begin
            failures++;
            $display("FAIL rst_video got=%h exp=0",
                     {vid.o_enable, vid.o_pixel, vid.o_pixel_x, vid.o_pixel_y});
        end
        rst = 1'b0;
        e0 = n_err;
        repeat (4) cyc(1'b1, 1'b0);
        checks++;
        if (n_err - e0 != 0) begin
            failures++;
            $display("FAIL rst_release_err got=%0d exp=0", n_err - e0);
        end
    endtask

    task automatic test_broad_lock();
        int e0, f0;
        logic fs_a, fs_b, fs_c, lk_b;
        e0 = n_err;
        f0 = n_fs;
        repeat (4) pulse(327, 384, 1'b0);
        checks++;
        if (o_locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_after4 got=%b exp=0", o_locked);
        end
        for (int k = 0; k < 384; k++) begin
            cyc(k >= 327, 1'b0);
            if (k == 327) fs_a = o_frame_start;
            if (k == 328) begin
                fs_b = o_frame_start;
                lk_b = o_locked;
            end
            if (k == 329) fs_c = o_frame_start;
        end
        checks++;
        if ({fs_a, fs_b, fs_c} !== 3'b010) begin
            failures++;
            $display("FAIL fs_timing got=%b exp=010", {fs_a, fs_b, fs_c});
        end
        checks++;
        if (lk_b !== 1'b1) begin
            failures++;
            $display("FAIL lock_after5 got=%b exp=1", lk_b);
        end
        checks++;
        if (n_fs - f0 != 1) begin
            failures++;
            $display("FAIL fs_count got=%0d exp=1", n_fs - f0);
        end
        checks++;
        if (n_err - e0 != 0) begin
            failures++;
            $display("FAIL lock_err got=%0d exp=0", n_err - e0);
        end
    endtask

    task automatic test_active_line();
        int en0, first, cnt, bad, ex, last_x;
        logic w, prev_w;
        en0 = n_en;
        repeat (4) pulse(30, 384, 1'b0);
        repeat (46) pulse(57, 768, 1'b0);
        checks++;
        if (n_en - en0 != 0 || o_locked !== 1'b1) begin
            failures++;
            $display("FAIL pre_line51 en=%0d lk=%b exp en=0 lk=1",
                     n_en - en0, o_locked);
        end
        first = -1; cnt = 0; bad = 0; ex = 0; last_x = -1; prev_w = 1'b0;
        for (int k = 0; k < 768; k++) begin
            w = (k >= 57) ? k[0] : 1'b0;
            cyc(k >= 57, w);
            if (vid.o_enable) begin
                if (first < 0) first = k;
                cnt++;
                if (int'(vid.o_pixel_x) != ex) bad++;
                if (vid.o_pixel_y !== 8'd0) bad++;
                if (vid.o_pixel !== prev_w) bad++;
                last_x = int'(vid.o_pixel_x);
                ex++;
            end else if ({vid.o_pixel, vid.o_pixel_x, vid.o_pixel_y} !== 18'd0) begin
                bad++;
            end
            prev_w = w;
        end
        checks++;
        if (first != 189) begin
            failures++;
            $display("FAIL en_first got=%0d exp=189", first);
        end
        checks++;
        if (cnt != 499) begin
            failures++;
            $display("FAIL en_len got=%0d exp=499", cnt);
        end
        checks++;
        if (last_x != 498) begin
            failures++;
            $display("FAIL last_x got=%0d exp=498", last_x);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pix_xy_bad got=%0d exp=0", bad);
        end
    endtask

    task automatic test_reset_midframe();
        logic en_pre;
        logic [20:0] snap;
        int f0, en0;
        for (int k = 0; k < 768; k++) begin
            rst = (k == 250);
            cyc(k >= 57, (k >= 57));
            if (k == 249) en_pre = vid.o_enable;
            if (k == 250)
                snap = {o_locked, o_frame_start, o_error, vid.o_enable,
                        vid.o_pixel, vid.o_pixel_x, vid.o_pixel_y};
        end
        checks++;
        if (en_pre !== 1'b1) begin
            failures++;
            $display("FAIL line52_en got=%b exp=1", en_pre);
        end
        checks++;
        if (snap !== 21'd0) begin
            failures++;
            $display("FAIL midrst_outs got=%h exp=0", snap);
        end
        f0 = n_fs;
        en0 = n_en;
        repeat (3) pulse(57, 768, 1'b1);
        checks++;
        if (o_locked !== 1'b0 || n_fs != f0 || n_en != en0) begin
            failures++;
            $display("FAIL midrst_relock lk=%b fs=%0d en=%0d exp 0 0 0",
                     o_locked, n_fs - f0, n_en - en0);
        end
    endtask

    task automatic test_boundary();
        int e0, f0;
        do_lock();
        e0 = n_err;
        pulse(45, 384, 1'b0);
        checks++;
        if (o_locked !== 1'b1 || n_err != e0) begin
            failures++;
            $display("FAIL w45 lk=%b err=%0d exp lk=1 err=0", o_locked, n_err - e0);
        end
        pulse(80, 384, 1'b0);
        checks++;
        if (o_locked !== 1'b1 || n_err != e0) begin
            failures++;
            $display("FAIL w80 lk=%b err=%0d exp lk=1 err=0", o_locked, n_err - e0);
        end
        pulse(81, 384, 1'b0);
        checks++;
        if (o_locked !== 1'b0 || n_err - e0 != 1) begin
            failures++;
            $display("FAIL w81 lk=%b err=%0d exp lk=0 err=1", o_locked, n_err - e0);
        end
        do_lock();
        e0 = n_err;
        pulse(44, 384, 1'b0);
        checks++;
        if (o_locked !== 1'b0 || n_err - e0 != 1) begin
            failures++;
            $display("FAIL w44 lk=%b err=%0d exp lk=0 err=1", o_locked, n_err - e0);
        end
        f0 = n_fs;
        repeat (4) pulse(327, 384, 1'b0);
        pulse(30, 384, 1'b0);
        pulse(327, 384, 1'b0);
        checks++;
        if (o_locked !== 1'b0 || n_fs != f0) begin
            failures++;
            $display("FAIL broad4_short lk=%b fs=%0d exp lk=0 fs=0",
                     o_locked, n_fs - f0);
        end
    endtask

    task automatic test_invalid_pulse();
        int e0, en0;
        do_lock();
        e0 = n_err;
        pulse(100, 768, 1'b0);
        checks++;
        if (o_locked !== 1'b0 || n_err - e0 != 1) begin
            failures++;
            $display("FAIL w100 lk=%b err=%0d exp lk=0 err=1", o_locked, n_err - e0);
        end
        en0 = n_en;
        repeat (2) pulse(57, 768, 1'b1);
        checks++;
        if (o_locked !== 1'b0 || n_en != en0) begin
            failures++;
            $display("FAIL w100_after lk=%b en=%0d exp 0 0", o_locked, n_en - en0);
        end
    endtask

    task automatic test_line_timeout();
        int e0;
        logic lk639, lk640;
        do_lock();
        e0 = n_err;
        for (int j = 0; j < 1100; j++) begin
            cyc(1'b1, 1'b0);
            if (j == 639) lk639 = o_locked;
            if (j == 640) lk640 = o_locked;
        end
        checks++;
        if ({lk639, lk640} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_edge got=%b exp=10", {lk639, lk640});
        end
        checks++;
        if (n_err - e0 != 1) begin
            failures++;
            $display("FAIL timeout_err got=%0d exp=1", n_err - e0);
        end
    endtask

    task automatic test_white_in_sync();
        int e0;
        do_lock();
        e0 = n_err;
        for (int k = 0; k < 768; k++)
            cyc(k >= 57, k == 20);
        checks++;
        if (n_err - e0 != 1 || o_locked !== 1'b1) begin
            failures++;
            $display("FAIL white_sync err=%0d lk=%b exp err=1 lk=1",
                     n_err - e0, o_locked);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_sync = 1'b1;
        i_white = 1'b0;
        test_reset();
        test_broad_lock();
        test_active_line();
        test_reset_midframe();
        test_boundary();
        test_invalid_pulse();
        test_line_timeout();
        test_white_in_sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_raw_decoder.md
VIDEO_RAW_DECODER -- requirements
Module: video_raw_decoder

Interface
REQ-001 Parameters (name, default, meaning): SHORT_MIN 20, SHORT_MAX 40 (short-sync low width, clocks); HSYNC_MIN 45, HSYNC_MAX 80; BROAD_MIN 250, BROAD_MAX 360; X_START 187 (line-count value of pixel x=0); X_WIDTH 499; Y_FIRST 51; Y_LAST 280; NUM_BROAD 5.
REQ-002 clk  in  1  12 MHz clock, the only clock.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 i_sync  in  1  composite sync level (0 = sync tip).
REQ-005 i_white  in  1  white level (1 = white, 0 = black).
REQ-006 o_pixel  out  1  recovered pixel; 0 when o_enable low.
REQ-007 o_enable  out  1  high when o_pixel_x/o_pixel_y are valid.
REQ-008 o_pixel_x  out  9  x coordinate 0-498; 0 when o_enable low.
REQ-009 o_pixel_y  out  8  y coordinate 0-229; 0 when o_enable low.
REQ-010 o_locked  out  1  frame timing acquired.
REQ-011 o_frame_start  out  1  one-cycle pulse on frame acquisition.
REQ-012 o_error  out  1  one-cycle pulse on protocol violation.

Function
REQ-013 i_sync and i_white each pass through one input register; all outputs are registered; o_pixel equals i_white delayed exactly 2 clocks whenever o_enable is high.
REQ-014 Falling edge = registered sync 1 in previous cycle, 0 in current; rising edge likewise inverted.
REQ-015 10-bit low_cnt clears on falling edge, increments while registered sync is low, saturates at 1023.
REQ-016 10-bit line_cnt clears to 0 on every falling edge, otherwise increments, saturates at 1023.
REQ-017 On rising edge the pulse is classified from low_cnt+1: SHORT, HSYNC, BROAD per inclusive MIN/MAX ranges; any other width is INVALID.
REQ-018 Consecutive-broad counter (3 bits): increments on BROAD, clears on any other class; on reaching NUM_BROAD it clears, line_no is set to 4, state becomes LOCKED, o_frame_start pulses — in any state.
REQ-019 States: SEARCH (reset state, o_locked 0) and LOCKED (o_locked 1); SEARCH→LOCKED only via REQ-018.
REQ-020 In LOCKED, HSYNC class increments 9-bit line_no; SHORT leaves it unchanged.
REQ-021 LOCKED→SEARCH, with o_error pulse, on: INVALID class; line_no would exceed 308; line_cnt reaching 1023; low_cnt reaching 1023.
REQ-022 In SEARCH, INVALID class and saturation do not pulse o_error.
REQ-023 registered i_white high while registered i_sync low pulses o_error in any state without changing state.
REQ-024 o_enable high iff LOCKED, Y_FIRST <= line_no <= Y_LAST, and X_START <= line_cnt <= X_START+X_WIDTH-1, evaluated one cycle before the output register.
REQ-025 o_pixel_x = line_cnt - X_START (9 bits), o_pixel_y = line_no - Y_FIRST (8 bits), both using the same-cycle values as REQ-024.
REQ-026 A falling edge coinciding with line_cnt saturation: the edge wins (line_cnt cleared), no lock loss.
REQ-027 Resulting timing: on qualifying lines o_enable first rises 189 clocks after the edge at which i_sync is first sampled low, stays high 499 clocks.

Reset
REQ-028 While rst is high, at each clock edge: state SEARCH, all counters and line_no 0, input registers 1 (sync) and 0 (white), all outputs 0.
REQ-029 rst asserted mid-frame aborts lock immediately; relock requires a fresh NUM_BROAD broad-sync sequence.

Structure
REQ-030 Class encoding, state encoding and default timing constants (12 MHz counts, line limits) live in a shared video timing package reused by video generator blocks.
REQ-031 One sub-module, video_pulse_classifier, contains input register, edge detect, low_cnt and class output; line/frame tracking stays in the top.

Verification
REQ-032 Five broad syncs (327 low/57 high) -> o_frame_start one pulse at 5th rising edge +1, o_locked 1, no o_error.
REQ-033 After lock, 4 short syncs then 47 hsync lines (57 low, 768 period), i_white=1 -> on line 51 o_enable high 499 clocks, o_pixel_x 0..498, o_pixel_y 0, o_pixel 1.
REQ-034 Locked, one 100-clock low pulse -> o_error pulse, o_locked 0, o_enable 0 thereafter.
REQ-035 Locked, i_sync held high 1100 clocks -> o_locked drops when line_cnt hits 1023, o_error pulse.
REQ-036 Boundary widths 44/45/80/81 clocks -> INVALID/HSYNC/HSYNC/INVALID; 4 broads then short -> no lock.
REQ-037 rst pulsed on line 100 -> all outputs 0 next cycle, no relock until next broad sequence.
